// File: rtl/mmu_dram_arbiter.sv
// mmu_dram_arbiter
//   Shares a single DRAM command port between the MMU page walker and
//   translated CPU accesses. The page walker has fixed priority. Only one
//   command is in flight at a time: IDLE -> ISSUE -> WAIT -> IDLE.
//
// Ports
//   CLK, RST_X       rising-edge clock, asynchronous active-low reset
//   pw_req/we/addr/wdata     page-walker PTE request (held until pw_done)
//   pw_rdata, pw_done        registered PTE read data, one-cycle completion
//   cpu_req/we/addr/wdata/wmask  CPU request (held until cpu_done)
//   cpu_rdata, cpu_done      registered CPU read data, one-cycle completion
//   dram_req/we/addr/wdata/wmask  DRAM command; dram_req strobes in ISSUE
//   dram_busy, dram_rdata, dram_valid  DRAM status and read return
//   busy             FSM is not in IDLE
//   err_timeout      sticky: a WAIT ran TIMEOUT cycles without completing
module mmu_dram_arbiter #(
  parameter int TIMEOUT = 255  // valid range 1..256 (8-bit WAIT counter)
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        pw_req,
  input  logic        pw_we,
  input  logic [31:0] pw_addr,
  input  logic [31:0] pw_wdata,
  output logic [31:0] pw_rdata,
  output logic        pw_done,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wmask,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        dram_req,
  output logic        dram_we,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  output logic [3:0]  dram_wmask,
  input  logic        dram_busy,
  input  logic [31:0] dram_rdata,
  input  logic        dram_valid,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Counter value in the last permitted WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        gnt_pw_reg, gnt_pw_next;
  logic        cmd_we_reg, cmd_we_next;
  logic [31:0] cmd_addr_reg, cmd_addr_next;
  logic [31:0] cmd_wdata_reg, cmd_wdata_next;
  logic [3:0]  cmd_wmask_reg, cmd_wmask_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] pw_rdata_reg, pw_rdata_next;
  logic [31:0] cpu_rdata_reg, cpu_rdata_next;
  logic        pw_done_reg, pw_done_next;
  logic        cpu_done_reg, cpu_done_next;
  logic        err_reg, err_next;
  logic        wait_done;

  // Writes finish once the controller drops busy; reads finish on data return.
  assign wait_done = cmd_we_reg ? !dram_busy : dram_valid;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_reg     <= ST_IDLE;
      gnt_pw_reg    <= 1'b0;
      cmd_we_reg    <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_wdata_reg <= '0;
      cmd_wmask_reg <= '0;
      cnt_reg       <= '0;
      pw_rdata_reg  <= '0;
      cpu_rdata_reg <= '0;
      pw_done_reg   <= 1'b0;
      cpu_done_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gnt_pw_reg    <= gnt_pw_next;
      cmd_we_reg    <= cmd_we_next;
      cmd_addr_reg  <= cmd_addr_next;
      cmd_wdata_reg <= cmd_wdata_next;
      cmd_wmask_reg <= cmd_wmask_next;
      cnt_reg       <= cnt_next;
      pw_rdata_reg  <= pw_rdata_next;
      cpu_rdata_reg <= cpu_rdata_next;
      pw_done_reg   <= pw_done_next;
      cpu_done_reg  <= cpu_done_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gnt_pw_next    = gnt_pw_reg;
    cmd_we_next    = cmd_we_reg;
    cmd_addr_next  = cmd_addr_reg;
    cmd_wdata_next = cmd_wdata_reg;
    cmd_wmask_next = cmd_wmask_reg;
    cnt_next       = cnt_reg;
    pw_rdata_next  = pw_rdata_reg;
    cpu_rdata_next = cpu_rdata_reg;
    pw_done_next   = 1'b0;
    cpu_done_next  = 1'b0;
    err_next       = err_reg;

    case (state_reg)
      ST_IDLE: begin
        // A requester still sees its done this cycle and has not yet dropped
        // req, so granting now would replay the finished access.
        if (!dram_busy && (pw_req || cpu_req) && !pw_done_reg && !cpu_done_reg) begin
          state_next = ST_ISSUE;
          if (pw_req) begin
            gnt_pw_next    = 1'b1;
            cmd_we_next    = pw_we;
            cmd_addr_next  = pw_addr;
            cmd_wdata_next = pw_wdata;
            cmd_wmask_next = 4'b1111;
          end else begin
            gnt_pw_next    = 1'b0;
            cmd_we_next    = cpu_we;
            cmd_addr_next  = cpu_addr;
            cmd_wdata_next = cpu_wdata;
            cmd_wmask_next = cpu_wmask;
          end
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
        cnt_next   = '0;
      end
      ST_WAIT: begin
        // Completion wins over timeout when both land on the last WAIT cycle.
        if (wait_done) begin
          state_next = ST_IDLE;
          if (gnt_pw_reg) begin
            pw_done_next = 1'b1;
            if (!cmd_we_reg) pw_rdata_next = dram_rdata;
          end else begin
            cpu_done_next = 1'b1;
            if (!cmd_we_reg) cpu_rdata_next = dram_rdata;
          end
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign dram_req    = (state_reg == ST_ISSUE);
  assign dram_we     = cmd_we_reg;
  assign dram_addr   = cmd_addr_reg;
  assign dram_wdata  = cmd_wdata_reg;
  assign dram_wmask  = cmd_wmask_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign pw_rdata    = pw_rdata_reg;
  assign cpu_rdata   = cpu_rdata_reg;
  assign pw_done     = pw_done_reg;
  assign cpu_done    = cpu_done_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_mmu_dram_arbiter.sv
// Testbench for mmu_dram_arbiter: directed table of scenarios, randomized
// scenarios with expectations from a behavioural model, and hand-written
// timeout and mid-transaction reset sequences.
module tb_mmu_dram_arbiter;
  localparam int TIMEOUT = 12;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        pw_req, pw_we, pw_done;
  logic [31:0] pw_addr, pw_wdata, pw_rdata;
  logic        cpu_req, cpu_we, cpu_done;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wmask;
  logic        dram_req, dram_we, dram_busy, dram_valid;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;
  logic [3:0]  dram_wmask;
  logic        busy, err_timeout;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_pw_rdata = '0;
  logic [31:0] exp_cpu_rdata = '0;

  always #5 clk = ~clk;

  mmu_dram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RST_X(rst_x),
    .pw_req(pw_req), .pw_we(pw_we), .pw_addr(pw_addr), .pw_wdata(pw_wdata),
    .pw_rdata(pw_rdata), .pw_done(pw_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wmask(cpu_wmask), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_wmask(dram_wmask), .dram_busy(dram_busy),
    .dram_rdata(dram_rdata), .dram_valid(dram_valid),
    .busy(busy), .err_timeout(err_timeout)
  );

  // One scenario: which ports request, DRAM behaviour, and expected timing.
  // lat: read -> dram_valid this many cycles after ISSUE;
  //      write -> dram_busy held this many cycles after ISSUE.
  typedef struct packed {
    bit          pw_en;
    bit          pw_we;
    logic [31:0] pw_addr;
    logic [31:0] pw_wdata;
    bit          cpu_en;
    bit          cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wmask;
    int          pre_busy;
    int          lat0;
    int          lat1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          e_issue0;  // cycle of first dram_req after req rises
    int          e_done0;   // done cycle minus issue cycle, command 0
    int          e_done1;
    logic [3:0]  e_mask0;
    logic [3:0]  e_mask1;
  } scn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " dram_req"}, 32'(dram_req), 0);
    chk({tag, " dram_we"}, 32'(dram_we), 0);
    chk({tag, " dram_addr"}, dram_addr, 0);
    chk({tag, " dram_wdata"}, dram_wdata, 0);
    chk({tag, " dram_wmask"}, 32'(dram_wmask), 0);
    chk({tag, " pw_rdata"}, pw_rdata, 0);
    chk({tag, " cpu_rdata"}, cpu_rdata, 0);
    chk({tag, " pw_done"}, 32'(pw_done), 0);
    chk({tag, " cpu_done"}, 32'(cpu_done), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " err_timeout"}, 32'(err_timeout), 0);
  endtask

  // Behavioural model: page walker goes first, the first grant waits for
  // dram_busy to clear, reads finish one cycle after data, writes two cycles
  // after the post-ISSUE busy window.
  function automatic scn_t model(input scn_t s);
    scn_t r;
    bit we0;
    r = s;
    we0 = s.pw_en ? s.pw_we : s.cpu_we;
    r.e_issue0 = s.pre_busy + 1;
    r.e_done0  = we0 ? s.lat0 + 2 : s.lat0 + 1;
    r.e_done1  = s.cpu_we ? s.lat1 + 2 : s.lat1 + 1;
    r.e_mask0  = s.pw_en ? 4'hF : s.cpu_wmask;
    r.e_mask1  = s.cpu_wmask;
    return r;
  endfunction

  task automatic run_scn(input scn_t s, input string tag);
    int n_cmd, issued, dones, end_cyc, k;
    int issue_cyc[2], done_cyc[2], lat[2], e_done[2];
    bit c_pw[2], c_we[2];
    logic [31:0] c_addr[2], c_wdata[2], c_rd[2];
    logic [3:0] e_mask[2], c_mask[2];
    bit finished;
    n_cmd = 0;
    if (s.pw_en) begin
      c_pw[n_cmd] = 1; c_we[n_cmd] = s.pw_we; c_addr[n_cmd] = s.pw_addr;
      c_wdata[n_cmd] = s.pw_wdata; c_mask[n_cmd] = 4'hF; n_cmd++;
    end
    if (s.cpu_en) begin
      c_pw[n_cmd] = 0; c_we[n_cmd] = s.cpu_we; c_addr[n_cmd] = s.cpu_addr;
      c_wdata[n_cmd] = s.cpu_wdata; c_mask[n_cmd] = s.cpu_wmask; n_cmd++;
    end
    lat[0] = s.lat0; lat[1] = s.lat1; c_rd[0] = s.rd0; c_rd[1] = s.rd1;
    e_done[0] = s.e_done0; e_done[1] = s.e_done1;
    e_mask[0] = s.e_mask0; e_mask[1] = s.e_mask1;
    issue_cyc[0] = -100; issue_cyc[1] = -100; done_cyc[0] = -100; done_cyc[1] = -100;
    issued = 0; dones = 0; end_cyc = -1; finished = 0;

    @(negedge clk);
    pw_req = s.pw_en; pw_we = s.pw_we; pw_addr = s.pw_addr; pw_wdata = s.pw_wdata;
    cpu_req = s.cpu_en; cpu_we = s.cpu_we; cpu_addr = s.cpu_addr;
    cpu_wdata = s.cpu_wdata; cpu_wmask = s.cpu_wmask;
    dram_busy = (s.pre_busy > 0); dram_valid = 0; dram_rdata = $urandom;

    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      if (dram_req) begin
        if (issued >= n_cmd) begin
          chk({tag, " extra_dram_req"}, 32'(dram_req), 0);
        end else begin
          k = issued;
          if (k == 0) chk({tag, " issue_cycle"}, 32'(cyc), 32'(s.e_issue0));
          else chk({tag, " issue_gap_after_done"}, 32'(cyc - done_cyc[0]), 2);
          chk({tag, " dram_we"}, 32'(dram_we), 32'(c_we[k]));
          chk({tag, " dram_addr"}, dram_addr, c_addr[k]);
          chk({tag, " dram_wdata"}, dram_wdata, c_wdata[k]);
          chk({tag, " dram_wmask"}, 32'(dram_wmask), 32'(e_mask[k]));
          chk({tag, " busy_in_issue"}, 32'(busy), 1);
          issue_cyc[k] = cyc;
          issued++;
        end
      end
      if (pw_done || cpu_done) begin
        if (dones >= issued) begin
          chk({tag, " unexpected_done"}, 32'({pw_done, cpu_done}), 0);
        end else begin
          k = dones;
          chk({tag, " done_port"}, 32'({pw_done, cpu_done}), c_pw[k] ? 32'd2 : 32'd1);
          chk({tag, " done_latency"}, 32'(cyc - issue_cyc[k]), 32'(e_done[k]));
          if (!c_we[k]) begin
            if (c_pw[k]) exp_pw_rdata = c_rd[k];
            else exp_cpu_rdata = c_rd[k];
          end
          chk({tag, " pw_rdata"}, pw_rdata, exp_pw_rdata);
          chk({tag, " cpu_rdata"}, cpu_rdata, exp_cpu_rdata);
          if (c_pw[k]) pw_req = 0;
          else cpu_req = 0;
          done_cyc[k] = cyc;
          dones++;
          if (dones == n_cmd) end_cyc = cyc + 2;
        end
      end
      if (cyc == end_cyc) begin
        finished = 1;
        break;
      end
      // DRAM behaviour for the remainder of this cycle; stray dram_valid is
      // injected whenever no read is waiting for data.
      dram_busy = (cyc < s.pre_busy);
      dram_rdata = $urandom;
      dram_valid = 0;
      if (issued > dones && cyc > issue_cyc[dones]) begin
        k = dones;
        if (c_we[k]) begin
          dram_busy = (cyc <= issue_cyc[k] + lat[k]);
          dram_valid = 1'($urandom_range(0, 1));
        end else if (cyc == issue_cyc[k] + lat[k]) begin
          dram_valid = 1;
          dram_rdata = c_rd[k];
        end
      end else begin
        dram_valid = 1'($urandom_range(0, 1));
      end
    end
    dram_valid = 0; dram_busy = 0; pw_req = 0; cpu_req = 0;
    chk({tag, " completed_in_budget"}, 32'(finished), 1);
    chk({tag, " commands_issued"}, 32'(issued), 32'(n_cmd));
    chk({tag, " dones_seen"}, 32'(dones), 32'(n_cmd));
    chk({tag, " busy_after"}, 32'(busy), 0);
    chk({tag, " err_timeout"}, 32'(err_timeout), 0);
    $display("txn %s pw=%0d cpu=%0d cmds=%0d dones=%0d pw_rdata=%08h cpu_rdata=%08h",
             tag, s.pw_en, s.cpu_en, issued, dones, pw_rdata, cpu_rdata);
  endtask

  scn_t tbl[$];
  scn_t s;
  int   mode, nreq, ndone;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_x = 0;
    pw_req = 0; pw_we = 0; pw_addr = '0; pw_wdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
    dram_busy = 0; dram_valid = 0; dram_rdata = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_x = 1;

    // ---- directed table ----
    s = '0; s.pw_en = 1; s.pw_addr = 32'h8000_1004; s.lat0 = 3; s.rd0 = 32'h2000_0C01;
    s.e_issue0 = 1; s.e_done0 = 4; s.e_mask0 = 4'hF; tbl.push_back(s);
    s = '0; s.pw_en = 1; s.pw_we = 1; s.pw_addr = 32'h8000_2008; s.pw_wdata = 32'h0000_00C1;
    s.cpu_en = 1; s.cpu_addr = 32'h8040_0000; s.lat0 = 1; s.lat1 = 2; s.rd1 = 32'h0BAD_F00D;
    s.e_issue0 = 1; s.e_done0 = 3; s.e_done1 = 3; s.e_mask0 = 4'hF; s.e_mask1 = 4'h0; tbl.push_back(s);
    s = '0; s.cpu_en = 1; s.cpu_we = 1; s.cpu_addr = 32'h8010_0010; s.cpu_wdata = 32'hDEAD_BEEF;
    s.cpu_wmask = 4'b0011; s.lat0 = 5; s.e_issue0 = 1; s.e_done0 = 7; s.e_mask0 = 4'b0011; tbl.push_back(s);
    s = '0; s.cpu_en = 1; s.cpu_addr = 32'h8020_0040; s.cpu_wmask = 4'hF; s.pre_busy = 10;
    s.lat0 = 1; s.rd0 = 32'h1357_9BDF; s.e_issue0 = 11; s.e_done0 = 2; s.e_mask0 = 4'hF; tbl.push_back(s);
    s = '0; s.pw_en = 1; s.pw_addr = 32'h8000_3000; s.lat0 = 1; s.rd0 = 32'hA5A5_5A5A;
    s.cpu_en = 1; s.cpu_we = 1; s.cpu_addr = 32'h8030_0004; s.cpu_wdata = 32'h0101_0101;
    s.cpu_wmask = 4'b1100; s.lat1 = 0; s.pre_busy = 3;
    s.e_issue0 = 4; s.e_done0 = 2; s.e_done1 = 2; s.e_mask0 = 4'hF; s.e_mask1 = 4'b1100; tbl.push_back(s);
    s = '0; s.pw_en = 1; s.pw_we = 1; s.pw_addr = 32'h8000_4000; s.pw_wdata = 32'h0000_0041;
    s.lat0 = 0; s.e_issue0 = 1; s.e_done0 = 2; s.e_mask0 = 4'hF; tbl.push_back(s);
    s = '0; s.cpu_en = 1; s.cpu_addr = 32'h8050_0000; s.cpu_wmask = 4'b0101; s.lat0 = TIMEOUT;
    s.rd0 = 32'h7777_0001; s.e_issue0 = 1; s.e_done0 = TIMEOUT + 1; s.e_mask0 = 4'b0101; tbl.push_back(s);
    for (int i = 0; i < tbl.size(); i++) run_scn(tbl[i], $sformatf("tbl%0d", i));

    // ---- randomized scenarios ----
    for (int i = 0; i < 30; i++) begin
      s = '0;
      mode = $urandom_range(1, 3);
      s.pw_en = mode[0]; s.cpu_en = mode[1];
      s.pw_we = 1'($urandom_range(0, 1)); s.pw_addr = $urandom; s.pw_wdata = $urandom;
      s.cpu_we = 1'($urandom_range(0, 1)); s.cpu_addr = $urandom; s.cpu_wdata = $urandom;
      s.cpu_wmask = 4'($urandom);
      s.pre_busy = $urandom_range(0, 3);
      s.lat0 = ((s.pw_en ? s.pw_we : s.cpu_we) != 0) ? $urandom_range(0, 5) : $urandom_range(1, 6);
      s.lat1 = s.cpu_we ? $urandom_range(0, 5) : $urandom_range(1, 6);
      s.rd0 = $urandom; s.rd1 = $urandom;
      run_scn(model(s), $sformatf("rnd%0d", i));
    end

    // ---- timeout: cpu read that never returns data ----
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8060_0000; cpu_wmask = 4'hF;
    nreq = 0; ndone = 0;
    for (int cyc = 1; cyc <= TIMEOUT + 6; cyc++) begin
      @(negedge clk);
      if (dram_req) begin
        nreq++;
        chk("timeout issue_cycle", 32'(cyc), 1);
      end
      if (pw_done || cpu_done) ndone++;
      if (cyc == TIMEOUT + 1) begin
        chk("timeout last_wait busy", 32'(busy), 1);
        chk("timeout last_wait err", 32'(err_timeout), 0);
      end
      if (cyc == TIMEOUT + 2) begin
        chk("timeout idle busy", 32'(busy), 0);
        chk("timeout err set", 32'(err_timeout), 1);
        cpu_req = 0;
      end
      dram_valid = (cyc == TIMEOUT + 3);
      dram_rdata = 32'hFFFF_0000;
    end
    dram_valid = 0;
    chk("timeout dram_req_count", 32'(nreq), 1);
    chk("timeout no_done", 32'(ndone), 0);
    chk("timeout cpu_rdata_unchanged", cpu_rdata, exp_cpu_rdata);
    chk("timeout pw_rdata_unchanged", pw_rdata, exp_pw_rdata);
    chk("timeout err sticky", 32'(err_timeout), 1);
    $display("txn timeout dram_req=%0d done=%0d err_timeout=%0d", nreq, ndone, err_timeout);

    // ---- asynchronous reset during WAIT ----
    @(negedge clk);
    pw_req = 1; pw_we = 0; pw_addr = 32'h8000_5000;
    repeat (3) @(negedge clk);
    chk("rstwait busy_before", 32'(busy), 1);
    #2 rst_x = 0;
    #1 chk_all_zero("rstwait async");
    pw_req = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("rstwait held");
    rst_x = 1;
    exp_pw_rdata = '0; exp_cpu_rdata = '0;
    $display("txn reset_in_wait busy=%0d err_timeout=%0d", busy, err_timeout);
    s = '0; s.cpu_en = 1; s.cpu_addr = 32'h8070_0008; s.cpu_wmask = 4'b1001; s.lat0 = 2;
    s.rd0 = 32'hC0DE_0042; s.e_issue0 = 1; s.e_done0 = 3; s.e_mask0 = 4'b1001;
    run_scn(s, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmu_dram_arbiter.md
MMU_DRAM_ARBITER -- requirements
Module: m_mmu_dram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before a timeout error is flagged.
REQ-002 SHALL have port CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port RST_X  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port pw_req  in  1  page-walker PTE access request, held high until pw_done.
REQ-005 SHALL have port pw_we  in  1  1 = PTE write (A/D update), 0 = PTE read.
REQ-006 SHALL have port pw_addr  in  32  PTE physical address.
REQ-007 SHALL have port pw_wdata  in  32  PTE write data.
REQ-008 SHALL have port pw_rdata  out  32  PTE read data, registered.
REQ-009 SHALL have port pw_done  out  1  one-cycle completion pulse for the page-walker port.
REQ-010 SHALL have port cpu_req  in  1  translated CPU access request, held high until cpu_done.
REQ-011 SHALL have port cpu_we  in  1  CPU write enable.
REQ-012 SHALL have port cpu_addr  in  32  CPU physical address.
REQ-013 SHALL have port cpu_wdata  in  32  CPU write data.
REQ-014 SHALL have port cpu_wmask  in  4  CPU byte-write mask.
REQ-015 SHALL have port cpu_rdata  out  32  CPU read data, registered.
REQ-016 SHALL have port cpu_done  out  1  one-cycle completion pulse for the CPU port.
REQ-017 SHALL have port dram_req  out  1  one-cycle DRAM command strobe.
REQ-018 SHALL have port dram_we  out  1  DRAM write enable.
REQ-019 SHALL have port dram_addr  out  32  DRAM address.
REQ-020 SHALL have port dram_wdata  out  32  DRAM write data.
REQ-021 SHALL have port dram_wmask  out  4  DRAM byte-write mask.
REQ-022 SHALL have port dram_busy  in  1  DRAM controller busy.
REQ-023 SHALL have port dram_rdata  in  32  DRAM read data.
REQ-024 SHALL have port dram_valid  in  1  DRAM read data valid, one cycle.
REQ-025 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-026 SHALL have port err_timeout  out  1  sticky timeout flag.

Function
REQ-027 SHALL implement a three-state FSM: IDLE -> ISSUE -> WAIT -> IDLE.
REQ-028 In IDLE with !dram_busy and (pw_req | cpu_req), SHALL grant pw if pw_req, else cpu (fixed priority to the page walker), register addr/we/wdata/wmask of the winner, and go to ISSUE.
REQ-029 For a pw grant, dram_wmask SHALL be 4'b1111.
REQ-030 In IDLE with dram_busy high, SHALL grant nothing and stay in IDLE.
REQ-031 In ISSUE, dram_req SHALL be 1 for exactly one cycle with the registered command; the FSM SHALL then go to WAIT unconditionally. dram_req SHALL be 0 in all other states.
REQ-032 In WAIT, a read SHALL complete on dram_valid: dram_rdata is captured into the granted port's rdata register, and that port's done pulses in the following cycle.
REQ-033 In WAIT, a write SHALL complete on the first cycle with dram_busy low; the granted port's done pulses in the following cycle.
REQ-034 On completion the FSM SHALL return to IDLE, with done asserted during that first IDLE cycle.
REQ-035 The requester SHALL drop req in the cycle done is high; the arbiter SHALL NOT grant during a cycle in which any done is high.
REQ-036 The non-granted port's rdata and done SHALL remain unchanged and 0 respectively.
REQ-037 Latency for a read with dram_valid N cycles after ISSUE SHALL be: grant edge, then ISSUE 1 cycle, then done N+1 cycles after ISSUE.
REQ-038 SHALL count WAIT cycles in an 8-bit counter cleared on entering WAIT; when the count reaches TIMEOUT, err_timeout SHALL set, the FSM SHALL return to IDLE, no done SHALL pulse, and rdata SHALL be unchanged.
REQ-039 err_timeout SHALL be sticky until reset.
REQ-040 A pw_req and a cpu_req asserted in the same cycle SHALL serve pw first, then cpu on the next IDLE with dram_busy low.
REQ-041 A dram_valid outside WAIT SHALL be ignored.

Reset
REQ-042 While RST_X=0, SHALL set state=IDLE; dram_req, dram_we, pw_done, cpu_done, busy, err_timeout = 0; dram_addr, dram_wdata, pw_rdata, cpu_rdata = 0; dram_wmask = 0; counter = 0.
REQ-043 Reset asserted mid-transaction SHALL abort it with no done pulse; the first grant is possible in the first cycle after RST_X rises.

Verification
REQ-044 pw read: pw_req=1, pw_addr=0x8000_1004, dram_valid 3 cycles after ISSUE with rdata 0x2000_0C01 -> exactly one dram_req with addr 0x8000_1004, we=0; pw_rdata=0x2000_0C01; pw_done is a single pulse.
REQ-045 Simultaneous pw_req (write, wdata 0x0000_00C1) and cpu_req (read 0x8040_0000) -> first dram_req is we=1, addr=pw_addr, mask=1111; second is the cpu read; cpu_done follows pw_done.
REQ-046 cpu write with wmask=4'b0011 and dram_busy held 5 cycles after ISSUE -> dram_wmask=0011; cpu_done one cycle after busy falls.
REQ-047 dram_busy=1 in IDLE with cpu_req=1 for 10 cycles -> no dram_req; grant occurs in the cycle after busy falls.
REQ-048 Read with no dram_valid -> err_timeout=1 after TIMEOUT WAIT cycles, no done, FSM in IDLE.
REQ-049 RST_X pulsed low during WAIT -> all outputs 0 immediately (asynchronous); a later request completes normally.
